diagv2_mem_ctrl: RTL and testbench
==================================

Name: diagv2_mem_ctrl

Overview:
Parametrised unified memory subsystem for the next diagv2 generation. It replaces the separate zero-latency instruction and data memories with one shared single-port RAM, serving a fetch port and a load/store port. Each port uses a req/ready handshake, so the core stalls on programmable wait states and on port conflicts. It also performs byte-lane steering, load sign/zero extension and misalignment detection that the core previously had no path for.

Parameters:
XLEN, 64, data bus width; RAM word width is XLEN; only 64 is required.
ILEN, 32, instruction width.
DEPTH, 4096, number of XLEN-bit RAM words; power of two.
LATENCY, 1, extra wait cycles per access, range 0..15.
INIT_FILE, "", hex image loaded at elaboration when non-empty.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
i_req  in  1  fetch request; held until i_ready
i_addr  in  XLEN  fetch byte address
i_ready  out  1  one-cycle completion pulse for fetch
i_rdata  out  ILEN  fetched instruction, valid while i_ready=1
i_err  out  1  fetch misaligned (i_addr[1:0]!=0), valid with i_ready
d_req  in  1  data request; held until d_ready
d_we  in  1  1=store, 0=load
d_type  in  3  funct3 encoding: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
d_addr  in  XLEN  data byte address
d_wdata  in  XLEN  store data, right-aligned
d_ready  out  1  one-cycle completion pulse for data
d_rdata  out  XLEN  extended load result, valid with d_ready; 0 for stores
d_err  out  1  data misaligned, valid with d_ready

Behaviour:
- Reset: state=IDLE; i_ready, d_ready, i_err, d_err=0; i_rdata, d_rdata=0; wait counter=0; last_grant=FETCH. RAM contents are not cleared.
- FSM states are IDLE, WAIT, RESP.
- IDLE:
  - Only d_req pending: grant DATA.
  - Only i_req pending: grant FETCH.
  - Both pending: grant the port that is not last_grant (round-robin). After reset, data wins the first conflict.
  - On grant: latch addr/type/we/wdata, set last_grant, cnt<=LATENCY, go to WAIT.
- WAIT:
  - cnt!=0: decrement.
  - cnt==0: perform the RAM access at this clock edge and register the formatted result, then go to RESP.
- RESP: assert the granted port's ready for exactly one cycle, then go to IDLE.
- Latency: request seen in IDLE at cycle 0 -> ready at cycle LATENCY+2. Minimum spacing between grants is LATENCY+3 cycles.
- Requesters must deassert or change req in the cycle after ready. req sampled during WAIT/RESP is ignored until IDLE.
- RAM indexing:
  - Word index = addr[log2(DEPTH)+2:3]; upper address bits are ignored, so addresses wrap modulo DEPTH*8 bytes.
  - Byte lane = addr[2:0].
- Fetch: returns bits [63:32] of the word when i_addr[2]=1, else [31:0].
- Loads: select the lane(s), then sign-extend (B/H/W) or zero-extend (BU/HU/WU/D) to XLEN.
- Stores: write only the lanes covered by size at offset addr[2:0]; other bytes are unchanged.
- Misalignment:
  - H requires addr[0]=0; W requires addr[1:0]=0; D requires addr[2:0]=0.
  - On violation: no RAM write, rdata=0, err=1 with the ready pulse.
  - Latency is identical to a normal access.
- d_type=111 is treated as misaligned (err=1, no write).
- Reset asserted in any state aborts the access. A store whose commit edge coincides with reset is not written; reset has priority.
- Simultaneous i_req and d_req when last_grant=DATA: fetch is served first, data waits one full access.

Test Plan:
- LATENCY=0: store D 0x1122334455667788 @0x100, then load D @0x100 -> d_ready exactly 2 cycles after each d_req; d_rdata=0x1122334455667788.
- Byte/half extension: store B 0x80 @0x203, load B @0x203 -> 0xFFFFFFFFFFFFFF80; load BU -> 0x80. Bytes 0x200–0x202 and 0x204–0x207 are unchanged.
- Arbitration, LATENCY=2: i_req and d_req asserted in the same cycle after reset -> d_ready at cycle 4, i_ready at cycle 9. Repeat the conflict -> fetch served first.
- Misaligned: load W @0x102 -> d_err=1, d_rdata=0. Store H @0x301 -> d_err=1 and a later read of word 0x300 is unchanged. Fetch @0x2 -> i_err=1.
- Wrap: DEPTH=4096, store W 0xDEADBEEF @0x8000 -> load W @0x0 returns 0xFFFFFFFFDEADBEEF. Fetch @0x4 returns the upper half of word 0.
- Reset mid-op: LATENCY=3, store issued, reset pulsed on the commit cycle -> no ready pulse, RAM unchanged, FSM in IDLE next cycle.

Source files
------------

// File: rtl/diagv2_mem_ctrl.sv
// Shared single-port RAM serving a fetch port and a load/store port, round-robin arbitrated.
// Ready pulses LATENCY+2 cycles after the grant cycle; a requester holds req until ready.
module diagv2_mem_ctrl #(
   parameter int    XLEN      = 64,
   parameter int    ILEN      = 32,
   parameter int    DEPTH     = 4096,
   parameter int    LATENCY   = 1,
   parameter string INIT_FILE = ""
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_req,
   input  logic [XLEN-1:0] i_addr,
   output logic            i_ready,
   output logic [ILEN-1:0] i_rdata,
   output logic            i_err,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [2:0]      d_type,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   output logic            d_ready,
   output logic [XLEN-1:0] d_rdata,
   output logic            d_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 3;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state, stateNext;
   logic [3:0]        cnt;
   logic              lastGrantData, grantData;
   logic [LW-1:0]     addrQ;
   logic [2:0]        typeQ;
   logic              weQ;
   logic [XLEN-1:0]   wdataQ;
   logic [XLEN-1:0]   mem [DEPTH];

   logic              pickData, grantEn, accessEn;
   logic [AW-1:0]     wordIdx;
   logic [2:0]        lane;
   logic [5:0]        shamt;
   logic [XLEN-1:0]   ramWord, shifted, loadVal, sizeMask, laneMask, merged;
   logic [ILEN-1:0]   fetchVal;
   logic              misalign;
   logic [2*(XLEN-LW)-1:0] unusedAddrBits;

   assign unusedAddrBits = {i_addr[XLEN-1:LW], d_addr[XLEN-1:LW]};

   always_comb begin
      stateNext = state;
      pickData  = 1'b0;
      grantEn   = 1'b0;
      accessEn  = 1'b0;
      case (state)
         IDLE: begin
            // On a conflict the port that did not win last time gets the RAM.
            if (d_req && i_req) pickData = !lastGrantData;
            else                pickData = d_req;
            if (d_req || i_req) begin
               grantEn   = 1'b1;
               stateNext = WAIT;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               accessEn  = 1'b1;
               stateNext = RESP;
            end
         end
         RESP:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      wordIdx  = addrQ[LW-1:3];
      lane     = addrQ[2:0];
      shamt    = {lane, 3'b000};
      ramWord  = mem[wordIdx];
      shifted  = ramWord >> shamt;
      loadVal  = shifted;
      sizeMask = '0;
      misalign = 1'b0;
      if (grantData) begin
         case (typeQ)
            3'b000: begin
               loadVal  = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
               sizeMask = {{(XLEN-8){1'b0}}, 8'hFF};
            end
            3'b100: begin
               loadVal  = {{(XLEN-8){1'b0}}, shifted[7:0]};
               sizeMask = {{(XLEN-8){1'b0}}, 8'hFF};
            end
            3'b001: begin
               misalign = lane[0];
               loadVal  = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
               sizeMask = {{(XLEN-16){1'b0}}, 16'hFFFF};
            end
            3'b101: begin
               misalign = lane[0];
               loadVal  = {{(XLEN-16){1'b0}}, shifted[15:0]};
               sizeMask = {{(XLEN-16){1'b0}}, 16'hFFFF};
            end
            3'b010: begin
               misalign = (lane[1:0] != 2'b00);
               loadVal  = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
               sizeMask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
            end
            3'b110: begin
               misalign = (lane[1:0] != 2'b00);
               loadVal  = {{(XLEN-32){1'b0}}, shifted[31:0]};
               sizeMask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
            end
            3'b011: begin
               misalign = (lane != 3'b000);
               loadVal  = shifted;
               sizeMask = '1;
            end
            default: misalign = 1'b1;
         endcase
      end else begin
         misalign = (lane[1:0] != 2'b00);
      end
      // Store data arrives right-aligned; the lane mask also drops bits beyond the access size.
      laneMask = sizeMask << shamt;
      merged   = (ramWord & ~laneMask) | ((wdataQ << shamt) & laneMask);
      fetchVal = lane[2] ? ramWord[2*ILEN-1:ILEN] : ramWord[ILEN-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= 4'd0;
         lastGrantData <= 1'b0;
         grantData     <= 1'b0;
         addrQ         <= '0;
         typeQ         <= 3'b000;
         weQ           <= 1'b0;
         wdataQ        <= '0;
         i_ready       <= 1'b0;
         i_rdata       <= '0;
         i_err         <= 1'b0;
         d_ready       <= 1'b0;
         d_rdata       <= '0;
         d_err         <= 1'b0;
      end else begin
         state   <= stateNext;
         i_ready <= 1'b0;
         d_ready <= 1'b0;
         if (grantEn) begin
            grantData     <= pickData;
            lastGrantData <= pickData;
            cnt           <= 4'(LATENCY);
            if (pickData) begin
               addrQ  <= d_addr[LW-1:0];
               typeQ  <= d_type;
               weQ    <= d_we;
               wdataQ <= d_wdata;
            end else begin
               addrQ  <= i_addr[LW-1:0];
               typeQ  <= 3'b000;
               weQ    <= 1'b0;
               wdataQ <= '0;
            end
         end
         if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
         if (accessEn) begin
            if (grantData) begin
               d_ready <= 1'b1;
               d_err   <= misalign;
               d_rdata <= (misalign || weQ) ? '0 : loadVal;
            end else begin
               i_ready <= 1'b1;
               i_err   <= misalign;
               i_rdata <= misalign ? '0 : fetchVal;
            end
         end
      end
   end

   // RAM is never cleared; a store whose commit edge sees reset is dropped.
   always_ff @(posedge clk) begin
      if (!reset && accessEn && grantData && weQ && !misalign) mem[wordIdx] <= merged;
   end
endmodule

// File: tb/tb_diagv2_mem_ctrl.sv
// Directed bench for diagv2_mem_ctrl at LATENCY 0, 2 and 3 with a queue-based scoreboard.
module tb_diagv2_mem_ctrl;
   localparam int N = 3;
   localparam logic [2:0] TB = 3'b000, TH = 3'b001, TW = 3'b010, TD = 3'b011;
   localparam logic [2:0] TBU = 3'b100, THU = 3'b101, TWU = 3'b110, TBAD = 3'b111;

   typedef struct {
      logic [63:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst    [N];
   logic        iReq   [N];
   logic [63:0] iAddr  [N];
   logic        iReady [N];
   logic [31:0] iRdata [N];
   logic        iErr   [N];
   logic        dReq   [N];
   logic        dWe    [N];
   logic [2:0]  dType  [N];
   logic [63:0] dAddr  [N];
   logic [63:0] dWdata [N];
   logic        dReady [N];
   logic [63:0] dRdata [N];
   logic        dErr   [N];

   exp_t expQ [2*N][$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   diagv2_mem_ctrl #(.XLEN(64), .ILEN(32), .DEPTH(4096), .LATENCY(0), .INIT_FILE("")) u0 (
      .clk(clk), .reset(rst[0]),
      .i_req(iReq[0]), .i_addr(iAddr[0]), .i_ready(iReady[0]), .i_rdata(iRdata[0]), .i_err(iErr[0]),
      .d_req(dReq[0]), .d_we(dWe[0]), .d_type(dType[0]), .d_addr(dAddr[0]), .d_wdata(dWdata[0]),
      .d_ready(dReady[0]), .d_rdata(dRdata[0]), .d_err(dErr[0]));

   diagv2_mem_ctrl #(.XLEN(64), .ILEN(32), .DEPTH(4096), .LATENCY(2), .INIT_FILE("")) u1 (
      .clk(clk), .reset(rst[1]),
      .i_req(iReq[1]), .i_addr(iAddr[1]), .i_ready(iReady[1]), .i_rdata(iRdata[1]), .i_err(iErr[1]),
      .d_req(dReq[1]), .d_we(dWe[1]), .d_type(dType[1]), .d_addr(dAddr[1]), .d_wdata(dWdata[1]),
      .d_ready(dReady[1]), .d_rdata(dRdata[1]), .d_err(dErr[1]));

   diagv2_mem_ctrl #(.XLEN(64), .ILEN(32), .DEPTH(4096), .LATENCY(3), .INIT_FILE("")) u2 (
      .clk(clk), .reset(rst[2]),
      .i_req(iReq[2]), .i_addr(iAddr[2]), .i_ready(iReady[2]), .i_rdata(iRdata[2]), .i_err(iErr[2]),
      .d_req(dReq[2]), .d_we(dWe[2]), .d_type(dType[2]), .d_addr(dAddr[2]), .d_wdata(dWdata[2]),
      .d_ready(dReady[2]), .d_rdata(dRdata[2]), .d_err(dErr[2]));

   function automatic int latOf(int k);
      return (k == 0) ? 0 : (k == 1) ? 2 : 3;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic pushExp(int q, logic [63:0] data, logic err, int c);
      exp_t e;
      e.data = data;
      e.err  = err;
      e.cyc  = c;
      expQ[q].push_back(e);
   endtask

   // Monitor: queue index 2*k is fetch of DUT k, 2*k+1 is data.
   task automatic popCheck(int q, logic [63:0] data, logic err);
      exp_t e;
      string tag;
      tag = $sformatf("dut%0d.%s", q / 2, (q % 2) ? "d" : "i");
      if (expQ[q].size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s unexpected ready: got data %h err %0b expected no response", tag, data, err);
      end else begin
         e = expQ[q].pop_front();
         check({tag, " rdata"}, data, e.data);
         check({tag, " err"}, {63'd0, err}, {63'd0, e.err});
         check({tag, " ready cycle"}, 64'(cyc), 64'(e.cyc));
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < N; k++) begin
         if (iReady[k]) popCheck(2*k, {32'd0, iRdata[k]}, iErr[k]);
         if (dReady[k]) popCheck(2*k+1, dRdata[k], dErr[k]);
      end
   end

   task automatic waitDone(int k, bit isData);
      bit seen = 1'b0;
      for (int c = 0; c < 60 && !seen; c++) begin
         @(negedge clk);
         seen = isData ? dReady[k] : iReady[k];
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL dut%0d %s ready timeout: got none expected pulse within 60 cycles", k, isData ? "d" : "i");
      end
      @(posedge clk); #1;
      if (isData) dReq[k] = 1'b0;
      else        iReq[k] = 1'b0;
   endtask

   task automatic dataOp(int k, bit we, logic [2:0] t, logic [63:0] a, logic [63:0] wd,
                         logic [63:0] expD, bit expE);
      @(posedge clk); #1;
      dReq[k] = 1'b1; dWe[k] = we; dType[k] = t; dAddr[k] = a; dWdata[k] = wd;
      pushExp(2*k+1, expD, expE, cyc + latOf(k) + 2);
      waitDone(k, 1'b1);
   endtask

   task automatic fetchOp(int k, logic [63:0] a, logic [31:0] expD, bit expE);
      @(posedge clk); #1;
      iReq[k] = 1'b1; iAddr[k] = a;
      pushExp(2*k, {32'd0, expD}, expE, cyc + latOf(k) + 2);
      waitDone(k, 1'b0);
   endtask

   // Both ports request in the same cycle; each drops its request the cycle after its ready.
   task automatic conflict(int k, bit dataFirst, bit we, logic [2:0] t, logic [63:0] a,
                           logic [63:0] wd, logic [63:0] expD, logic [63:0] fa, logic [31:0] expI);
      int  first, second;
      bit  dDone = 1'b0, iDone = 1'b0, dSeen, iSeen;
      @(posedge clk); #1;
      dReq[k] = 1'b1; dWe[k] = we; dType[k] = t; dAddr[k] = a; dWdata[k] = wd;
      iReq[k] = 1'b1; iAddr[k] = fa;
      first  = cyc + latOf(k) + 2;
      second = cyc + 2*latOf(k) + 5;
      pushExp(2*k+1, expD, 1'b0, dataFirst ? first : second);
      pushExp(2*k, {32'd0, expI}, 1'b0, dataFirst ? second : first);
      for (int c = 0; c < 80 && !(dDone && iDone); c++) begin
         @(negedge clk);
         dSeen = dReady[k];
         iSeen = iReady[k];
         @(posedge clk); #1;
         if (dSeen) begin dReq[k] = 1'b0; dDone = 1'b1; end
         if (iSeen) begin iReq[k] = 1'b0; iDone = 1'b1; end
      end
      checks++;
      if (!(dDone && iDone)) begin
         errors++;
         $display("FAIL dut%0d conflict timeout: got d=%0b i=%0b expected both done", k, dDone, iDone);
      end
   endtask

   initial begin
      int t;
      for (int k = 0; k < N; k++) begin
         rst[k] = 1'b1; iReq[k] = 1'b0; iAddr[k] = '0; dReq[k] = 1'b0; dWe[k] = 1'b0;
         dType[k] = TB; dAddr[k] = '0; dWdata[k] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         check($sformatf("dut%0d reset outputs", k),
               {iReady[k], dReady[k], iErr[k], dErr[k], 28'd0, iRdata[k] | dRdata[k][31:0] | dRdata[k][63:32]},
               64'd0);
         rst[k] = 1'b0;
      end

      // LATENCY 0: basic D round trip, byte/half/word extension, misalignment, wrap
      dataOp(0, 1, TD, 64'h100, 64'h1122334455667788, 64'h0, 0);
      dataOp(0, 0, TD, 64'h100, 64'h0, 64'h1122334455667788, 0);
      dataOp(0, 1, TD, 64'h200, 64'h0123456789ABCDEF, 64'h0, 0);
      dataOp(0, 1, TB, 64'h203, 64'hFFFFFFFFFFFFFF80, 64'h0, 0);
      dataOp(0, 0, TB, 64'h203, 64'h0, 64'hFFFFFFFFFFFFFF80, 0);
      dataOp(0, 0, TBU, 64'h203, 64'h0, 64'h0000000000000080, 0);
      dataOp(0, 0, TD, 64'h200, 64'h0, 64'h0123456780ABCDEF, 0);
      dataOp(0, 0, TH, 64'h202, 64'h0, 64'hFFFFFFFFFFFF80AB, 0);
      dataOp(0, 0, THU, 64'h202, 64'h0, 64'h00000000000080AB, 0);
      dataOp(0, 0, TWU, 64'h204, 64'h0, 64'h0000000001234567, 0);
      dataOp(0, 0, TW, 64'h102, 64'h0, 64'h0, 1);
      dataOp(0, 1, TD, 64'h300, 64'hA1A2A3A4A5A6A7A8, 64'h0, 0);
      dataOp(0, 1, TH, 64'h301, 64'h000000000000BEEF, 64'h0, 1);
      dataOp(0, 0, TD, 64'h300, 64'h0, 64'hA1A2A3A4A5A6A7A8, 0);
      dataOp(0, 0, TBAD, 64'h100, 64'h0, 64'h0, 1);
      fetchOp(0, 64'h2, 32'h0, 1);
      dataOp(0, 1, TW, 64'h8000, 64'h00000000DEADBEEF, 64'h0, 0);
      dataOp(0, 1, TW, 64'h4, 64'h0000000013579BDF, 64'h0, 0);
      dataOp(0, 0, TW, 64'h0, 64'h0, 64'hFFFFFFFFDEADBEEF, 0);
      dataOp(0, 0, TD, 64'h8000, 64'h0, 64'h13579BDFDEADBEEF, 0);
      fetchOp(0, 64'h4, 32'h13579BDF, 0);
      fetchOp(0, 64'h0, 32'hDEADBEEF, 0);

      // LATENCY 2: first conflict after reset goes to data; fetch then sees the stored word
      conflict(1, 1, 1, TD, 64'h10, 64'hCAFEF00D11223344, 64'h0, 64'h10, 32'h11223344);
      dataOp(1, 1, TD, 64'h10, 64'h5555666677778888, 64'h0, 0);
      // last grant was data, so fetch wins and reads the old upper half
      conflict(1, 0, 1, TD, 64'h10, 64'h9999AAAABBBBCCCC, 64'h0, 64'h14, 32'h55556666);
      dataOp(1, 0, TD, 64'h10, 64'h0, 64'h9999AAAABBBBCCCC, 0);

      // LATENCY 3: reset on the commit edge drops the store and the ready pulse
      dataOp(2, 1, TD, 64'h400, 64'hA5A5A5A5A5A5A5A5, 64'h0, 0);
      dataOp(2, 0, TD, 64'h400, 64'h0, 64'hA5A5A5A5A5A5A5A5, 0);
      @(posedge clk); #1;
      dReq[2] = 1'b1; dWe[2] = 1'b1; dType[2] = TD; dAddr[2] = 64'h400; dWdata[2] = 64'h0000000000001234;
      t = cyc;
      repeat (4) @(posedge clk);
      #1;
      rst[2] = 1'b1;
      @(posedge clk); #1;
      rst[2] = 1'b0;
      check("dut2 after abort ready/err", {62'd0, dReady[2], dErr[2]}, 64'd0);
      check("dut2 after abort rdata", dRdata[2], 64'd0);
      check("dut2 abort timing", 64'(cyc - t), 64'd5);
      dWe[2] = 1'b0;
      pushExp(5, 64'hA5A5A5A5A5A5A5A5, 1'b0, cyc + latOf(2) + 2);
      waitDone(2, 1'b1);

      repeat (10) @(posedge clk);
      for (int q = 0; q < 2*N; q++) check($sformatf("queue %0d leftover", q), 64'(expQ[q].size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
